// File: rtl/my_mult.sv
// Two-stage signed fixed-point multiplier. It multiplies two Q16.16 operands,
// scales the product into a saturated 14-bit DAC code and sign-extends the code to the bus width.
module my_mult #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 14,
  parameter int INT_WIDTH  = 16,
  parameter int BIT_SHIFT  = 0,
  parameter int INT_FORMAT = 2,
  parameter int DEC_FORMAT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p,
  output logic                  sat
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int SHIFT      = 2 * DEC_FORMAT - (OUT_WIDTH - INT_FORMAT) - BIT_SHIFT;
  localparam int SHIFT_AMT  = (SHIFT < 0) ? 0 : SHIFT;

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("my_mult: BIT_SHIFT too large, scaling shift would be negative");
    end
    if (INT_WIDTH + DEC_FORMAT != DATA_WIDTH) begin : g_bad_format
      $error("my_mult: INT_WIDTH + DEC_FORMAT must equal DATA_WIDTH");
    end
    if (OUT_WIDTH >= DATA_WIDTH) begin : g_bad_out
      $error("my_mult: OUT_WIDTH must be narrower than DATA_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]        a_reg, b_reg;
  logic [DATA_WIDTH-1:0]        p_reg, p_next;
  logic                         sat_reg, sat_next;
  logic signed [PROD_WIDTH-1:0] a_ext, b_ext, product, scaled;
  logic                         in_range;
  logic [OUT_WIDTH-1:0]         code_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      sat_reg <= 1'b0;
    end else begin
      a_reg   <= a;
      b_reg   <= b;
      p_reg   <= p_next;
      sat_reg <= sat_next;
    end
  end

  always_comb begin
    a_ext   = {{DATA_WIDTH{a_reg[DATA_WIDTH-1]}}, a_reg};
    b_ext   = {{DATA_WIDTH{b_reg[DATA_WIDTH-1]}}, b_reg};
    // The full-width product cannot overflow: even (-2^31)^2 = 2^62 fits.
    product = a_ext * b_ext;
    scaled  = product >>> SHIFT_AMT;

    // The value fits the code when every bit above the code's sign bit matches that sign bit.
    in_range = (&scaled[PROD_WIDTH-1:OUT_WIDTH-1]) | ~(|scaled[PROD_WIDTH-1:OUT_WIDTH-1]);

    code_next = scaled[OUT_WIDTH-1:0];
    sat_next  = 1'b0;
    if (!in_range) begin
      sat_next = 1'b1;
      if (scaled[PROD_WIDTH-1]) begin
        code_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        code_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end

    p_next = {{(DATA_WIDTH-OUT_WIDTH){code_next[OUT_WIDTH-1]}}, code_next};
  end

  assign p   = p_reg;
  assign sat = sat_reg;

endmodule

// File: tb/tb_my_mult.sv
// Scoreboard bench for my_mult. It drives a default build and a BIT_SHIFT=1 build in parallel.
// Expected codes come from table constants or from an arithmetic floor-division model.
module tb_my_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] p0, p1;
  logic        sat0, sat1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] p0;
    logic        s0;
    logic [31:0] p1;
    logic        s1;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p0;
    logic        s0;
    logic [31:0] p1;
    logic        s1;
  } vec_t;

  my_mult dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .p(p0), .sat(sat0)
  );

  my_mult #(.BIT_SHIFT(1)) dut_bs1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .p(p1), .sat(sat1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The reference divides the exact product by 2^(32-12-bit_shift) with floor semantics.
  // It then clips the quotient to the signed 14-bit code range.
  function automatic void model(input logic [31:0] ai, input logic [31:0] bi, input int bit_shift,
                                output logic [31:0] po, output logic so);
    longint pr, d, q;
    pr = longint'($signed(ai)) * longint'($signed(bi));
    d  = longint'(1) << (32 - 12 - bit_shift);
    q  = pr / d;
    if ((pr % d != 0) && (pr < 0)) q = q - 1;
    so = 1'b0;
    if (q > 8191) begin
      q  = 8191;
      so = 1'b1;
    end else if (q < -8192) begin
      q  = -8192;
      so = 1'b1;
    end
    po = 32'(q);
  endfunction

  task automatic drive(input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] ep0, input logic es0,
                       input logic [31:0] ep1, input logic es1);
    exp_t e;
    a = ai;
    b = bi;
    e.p0 = ep0; e.s0 = es0; e.p1 = ep1; e.s1 = es1; e.due = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive_model(input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] e0, e1;
    logic        s0, s1;
    model(ai, bi, 0, e0, s0);
    model(ai, bi, 1, e1, s1);
    drive(ai, bi, e0, s0, e1, s1);
  endtask

  // Monitor: each output is due exactly two edges after its inputs were sampled.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.due < cyc) begin
          tests++;
          fails++;
          $display("FAIL late_result: got nothing at cycle %0d expected result at cycle %0d", cyc, e.due);
        end else begin
          check("p", p0, e.p0);
          check("sat", {31'b0, sat0}, {31'b0, e.s0});
          check("p_bs1", p1, e.p1);
          check("sat_bs1", {31'b0, sat1}, {31'b0, e.s1});
        end
      end
    end
  end

  vec_t dir[8];

  initial begin
    dir[0] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0800, 1'b0, 32'h0000_1000, 1'b0};
    dir[1] = '{32'hFFFF_0000, 32'h0001_8000, 32'hFFFF_E800, 1'b0, 32'hFFFF_E000, 1'b1};
    dir[2] = '{32'h0001_0000, 32'h800A_0000, 32'hFFFF_E000, 1'b1, 32'hFFFF_E000, 1'b1};
    dir[3] = '{32'h0002_0000, 32'h0001_0000, 32'h0000_1FFF, 1'b1, 32'h0000_1FFF, 1'b1};
    dir[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_1FFF, 1'b1, 32'h0000_1FFF, 1'b1};
    dir[5] = '{32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    dir[6] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    dir[7] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    // Reset held with live operands: outputs must stay cleared.
    rst_n = 1'b0;
    a = 32'h0001_0000;
    b = 32'h0001_0000;
    repeat (3) @(negedge clk);
    check("reset_p", p0, 32'h0);
    check("reset_sat", {31'b0, sat0}, 32'h0);
    check("reset_p_bs1", p1, 32'h0);

    // Release, then issue back-to-back directed vectors, one per cycle.
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++)
      drive(dir[i].a, dir[i].b, dir[i].p0, dir[i].s0, dir[i].p1, dir[i].s1);

    // Random operands: full-range words mixed with small values that mostly avoid clipping.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      if (i % 4 == 0) begin
        ra = $urandom;
        rb = $urandom;
      end else begin
        ra = 32'(int'($urandom_range(0, 32'h7_FFFF)) - 32'h4_0000);
        rb = 32'(int'($urandom_range(0, 32'h7_FFFF)) - 32'h4_0000);
      end
      drive_model(ra, rb);
    end

    // Mid-pipeline asynchronous reset discards in-flight results.
    drive_model(32'h0002_0000, 32'h0000_4000);
    drive_model(32'h0003_0000, 32'hFFFF_C000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_p", p0, 32'h0);
    check("async_reset_sat", {31'b0, sat0}, 32'h0);
    check("async_reset_p_bs1", p1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(dir[0].a, dir[0].b, dir[0].p0, dir[0].s0, dir[0].p1, dir[0].s1);
    check("post_reset_empty_p", p0, 32'h0);
    drive(dir[2].a, dir[2].b, dir[2].p0, dir[2].s0, dir[2].p1, dir[2].s1);
    drive(dir[6].a, dir[6].b, dir[6].p0, dir[6].s0, dir[6].p1, dir[6].s1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d results still pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
